// File: rtl/rf_dump_engine.sv
// Streams a range of CPU register-file entries out as {addr, data} beats over valid/ready.
// Optional trailing XOR checksum beat when RF_DUMP_CHECKSUM_EN is defined.
module rf_dump_engine #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] debug_ra,
  input  logic [DATA_W-1:0] debug_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_is_sum
);

`ifdef RF_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, SUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

  state_t            state, state_d;
  logic [ADDR_W-1:0] cur, cur_d;
  logic [ADDR_W-1:0] lim, lim_d;
  logic              busy_d, done_d;
  logic [ADDR_W-1:0] debug_ra_d;
  logic              out_valid_d, out_last_d;
  logic [ADDR_W-1:0] out_addr_d;
  logic [DATA_W-1:0] out_data_d;
`ifdef RF_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc, acc_d;
  logic              is_sum, is_sum_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      lim       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      debug_ra  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      acc       <= '0;
      is_sum    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cur       <= cur_d;
      lim       <= lim_d;
      busy      <= busy_d;
      done      <= done_d;
      debug_ra  <= debug_ra_d;
      out_valid <= out_valid_d;
      out_addr  <= out_addr_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
`ifdef RF_DUMP_CHECKSUM_EN
      acc       <= acc_d;
      is_sum    <= is_sum_d;
`endif
    end
  end

  // Next-state and next-output logic; out_data doubles as the captured RF value
  always_comb begin
    state_d     = state;
    cur_d       = cur;
    lim_d       = lim;
    busy_d      = busy;
    done_d      = 1'b0;
    debug_ra_d  = debug_ra;
    out_valid_d = out_valid;
    out_addr_d  = out_addr;
    out_data_d  = out_data;
    out_last_d  = out_last;
`ifdef RF_DUMP_CHECKSUM_EN
    acc_d       = acc;
    is_sum_d    = is_sum;
`endif
    case (state)
      IDLE: begin
        debug_ra_d = '0;
        busy_d     = 1'b0;
        if (start) begin
          if (first_addr <= last_addr) begin
            cur_d      = first_addr;
            lim_d      = last_addr;
            debug_ra_d = first_addr;
            busy_d     = 1'b1;
            state_d    = FETCH;
`ifdef RF_DUMP_CHECKSUM_EN
            acc_d      = '0;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        out_valid_d = 1'b1;
        out_addr_d  = cur;
        out_data_d  = debug_rd;
`ifdef RF_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (cur == lim);
`endif
        debug_ra_d  = '0;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (cur == lim) begin
`ifdef RF_DUMP_CHECKSUM_EN
            acc_d       = acc ^ out_data;
            out_valid_d = 1'b1;
            out_addr_d  = '0;
            out_data_d  = acc ^ out_data;
            out_last_d  = 1'b1;
            is_sum_d    = 1'b1;
            state_d     = SUM;
`else
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
`endif
          end else begin
`ifdef RF_DUMP_CHECKSUM_EN
            acc_d      = acc ^ out_data;
`endif
            cur_d      = cur + ADDR_W'(1);
            debug_ra_d = cur + ADDR_W'(1);
            state_d    = FETCH;
          end
        end
      end
`ifdef RF_DUMP_CHECKSUM_EN
      SUM: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          is_sum_d    = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
`endif
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RF_DUMP_CHECKSUM_EN
  assign out_is_sum = is_sum;
`else
  assign out_is_sum = 1'b0;
`endif

endmodule
